// File: rtl/hmr_pkg.sv
// Shared definitions for the HMR redundancy controllers: mode encoding reported on state_o
// and the watchdog width helper.
package hmr_pkg;

    localparam int unsigned StateWidth = 3;

    typedef enum logic [StateWidth-1:0] {
        StIndep  = 3'd0,
        StRun    = 3'd1,
        StUnload = 3'd2,
        StReload = 3'd3,
        StRapid  = 3'd4
    } nmr_mode_e;

    // A disabled watchdog (timeout 0) still gets a 1-bit counter so the vector stays legal.
    function automatic int unsigned wd_width(int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/hmr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over a same-cycle count.
module hmr_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clear_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/hmr_nmr_ctrl.sv
// N-modular-redundancy control FSM for one HMR core group: resynch buffering, per-core
// mismatch counters, unload watchdog and entry/exit of redundant mode.
module hmr_nmr_ctrl
    import hmr_pkg::*;
#(
    parameter int unsigned NumCores      = 3,
    parameter int unsigned CntWidth      = 8,
    parameter int unsigned UnloadTimeout = 0,
    parameter bit          NMRFixed      = 1'b0,
    parameter bit          DefaultInNMR  = NMRFixed,
    parameter bit          RapidRecovery = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         nmr_enable_i,
    input  logic                         delay_resynch_i,
    input  logic                         setback_i,
    input  logic                         reload_setback_i,
    input  logic                         rapid_recovery_i,
    input  logic                         synch_req_i,
    input  logic                         force_resynch_i,
    input  logic                         cnt_clear_i,
    input  logic                         single_mismatch_i,
    input  logic [NumCores-1:0]          error_i,
    input  logic                         failure_i,
    input  logic                         sp_store_is_zero_i,
    input  logic                         sp_store_will_be_zero_i,
    input  logic                         fetch_en_i,
    input  logic                         cores_synch_i,
    input  logic                         recovery_finished_i,
    input  logic                         bus_resp_ok_i,
    output logic [NumCores-1:0]          setback_o,
    output logic                         sw_synch_req_o,
    output logic                         sw_resynch_req_o,
    output logic                         grp_in_independent_o,
    output logic                         rapid_recovery_en_o,
    output logic                         recovery_request_o,
    output logic                         bus_hold_o,
    output logic                         resynch_pending_o,
    output logic                         unload_timeout_o,
    output logic [NumCores*CntWidth-1:0] mismatch_cnt_o,
    output logic [StateWidth-1:0]        state_o
);

    localparam int unsigned WdWidth = wd_width(UnloadTimeout);
    localparam logic [WdWidth-1:0] WdLimit = WdWidth'(UnloadTimeout);
    localparam nmr_mode_e ResetState = DefaultInNMR ? StRun : StIndep;

    nmr_mode_e          state_q, state_d;
    logic               pending_q, pending_d;
    logic               cores_synch_q;
    logic               synch_sent_q, resynch_sent_q;
    logic               timeout_q;
    logic [WdWidth-1:0] wd_cnt_q, wd_cnt_d, wd_next;
    logic               wd_fire;
    logic               synch_req, resynch_req;
    logic               rr;
    logic               trigger;

    assign rr      = rapid_recovery_i & RapidRecovery;
    assign trigger = force_resynch_i | single_mismatch_i | pending_q;
    assign wd_next = wd_cnt_q + WdWidth'(1);

    // The counter holds the number of completed UNLOAD cycles; wd_next includes the current one.
    assign wd_cnt_d = (state_q == StUnload) ? wd_next : '0;

    always_comb begin
        state_d            = state_q;
        pending_d          = pending_q;
        setback_o          = '0;
        bus_hold_o         = 1'b0;
        recovery_request_o = 1'b0;
        synch_req          = 1'b0;
        resynch_req        = 1'b0;
        wd_fire            = 1'b0;

        case (state_q)
            StRun: begin
                if (trigger) begin
                    if (rr) begin
                        state_d   = StRapid;
                        pending_d = 1'b0;
                    end else if (!delay_resynch_i) begin
                        state_d   = StUnload;
                        pending_d = 1'b0;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
            end
            StUnload: begin
                resynch_req = 1'b1;
                if (!sp_store_is_zero_i) begin
                    state_d   = StReload;
                    setback_o = {NumCores{setback_i}};
                end
                if ((UnloadTimeout != 0) && (wd_next == WdLimit)) begin
                    wd_fire   = 1'b1;
                    state_d   = StReload;
                    setback_o = '1;
                end
            end
            StReload: begin
                if (sp_store_is_zero_i) begin
                    state_d = StRun;
                end else if ((single_mismatch_i | failure_i) & setback_i & reload_setback_i
                             & ~sp_store_will_be_zero_i) begin
                    setback_o = '1;
                end
            end
            StRapid: begin
                recovery_request_o = 1'b1;
                if (recovery_finished_i) begin
                    state_d = StRun;
                end
            end
            default: ;
        endcase

        if (!NMRFixed) begin
            if ((state_q == StIndep) && nmr_enable_i) begin
                synch_req = synch_req_i;
                if (cores_synch_q) begin
                    if (rr) begin
                        state_d = StRapid;
                    end else begin
                        state_d   = StReload;
                        setback_o = {NumCores{setback_i}};
                    end
                end
            end
            // Leaving redundancy: hold the bus and suppress recovery until the bus drains.
            if ((state_q == StRun) && !nmr_enable_i) begin
                bus_hold_o = 1'b1;
                state_d    = StRun;
                if (bus_resp_ok_i) begin
                    state_d   = StIndep;
                    pending_d = 1'b0;
                    setback_o = setback_i ? {{(NumCores-1){1'b1}}, 1'b0} : '0;
                end
            end
            if (!fetch_en_i) begin
                state_d   = nmr_enable_i ? StRun : StIndep;
                synch_req = 1'b0;
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ResetState;
            pending_q      <= 1'b0;
            cores_synch_q  <= 1'b0;
            synch_sent_q   <= 1'b0;
            resynch_sent_q <= 1'b0;
            timeout_q      <= 1'b0;
            wd_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            cores_synch_q  <= cores_synch_i;
            synch_sent_q   <= synch_req;
            resynch_sent_q <= resynch_req;
            wd_cnt_q       <= wd_cnt_d;
            if (cnt_clear_i) begin
                timeout_q <= 1'b0;
            end else if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NumCores; i++) begin : g_cnt
        hmr_sat_counter #(
            .Width(CntWidth)
        ) u_cnt (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (single_mismatch_i & error_i[i]),
            .clear_i (cnt_clear_i),
            .count_o (mismatch_cnt_o[i*CntWidth +: CntWidth])
        );
    end

    assign sw_synch_req_o       = synch_req & ~synch_sent_q;
    assign sw_resynch_req_o     = resynch_req & ~resynch_sent_q;
    assign grp_in_independent_o = (state_q == StIndep);
    assign rapid_recovery_en_o  = rr;
    assign resynch_pending_o    = pending_q;
    assign unload_timeout_o     = timeout_q;
    assign state_o              = state_q;

endmodule

// File: tb/tb_hmr_nmr_ctrl.sv
// Directed and randomized bench for hmr_nmr_ctrl (5 cores, 2-bit counters, 16-cycle watchdog).
module tb_hmr_nmr_ctrl;
    import hmr_pkg::*;

    localparam int unsigned N  = 5;
    localparam int unsigned CW = 2;
    localparam int unsigned UT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic nmr_enable, delay_resynch, setback, reload_setback, rapid_recovery, synch_req;
    logic force_resynch, cnt_clear, single_mismatch, failure;
    logic [N-1:0] error;
    logic sp_zero, will_be_zero, fetch_en, cores_synch, recovery_finished, bus_resp_ok;

    logic [N-1:0]    setback_o;
    logic            sw_synch_req_o, sw_resynch_req_o, grp_in_independent_o, rapid_recovery_en_o;
    logic            recovery_request_o, bus_hold_o, resynch_pending_o, unload_timeout_o;
    logic [N*CW-1:0] mismatch_cnt_o;
    logic [2:0]      state_o;

    hmr_nmr_ctrl #(
        .NumCores      (N),
        .CntWidth      (CW),
        .UnloadTimeout (UT),
        .NMRFixed      (1'b0),
        .DefaultInNMR  (1'b1),
        .RapidRecovery (1'b1)
    ) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .nmr_enable_i            (nmr_enable),
        .delay_resynch_i         (delay_resynch),
        .setback_i               (setback),
        .reload_setback_i        (reload_setback),
        .rapid_recovery_i        (rapid_recovery),
        .synch_req_i             (synch_req),
        .force_resynch_i         (force_resynch),
        .cnt_clear_i             (cnt_clear),
        .single_mismatch_i       (single_mismatch),
        .error_i                 (error),
        .failure_i               (failure),
        .sp_store_is_zero_i      (sp_zero),
        .sp_store_will_be_zero_i (will_be_zero),
        .fetch_en_i              (fetch_en),
        .cores_synch_i           (cores_synch),
        .recovery_finished_i     (recovery_finished),
        .bus_resp_ok_i           (bus_resp_ok),
        .setback_o               (setback_o),
        .sw_synch_req_o          (sw_synch_req_o),
        .sw_resynch_req_o        (sw_resynch_req_o),
        .grp_in_independent_o    (grp_in_independent_o),
        .rapid_recovery_en_o     (rapid_recovery_en_o),
        .recovery_request_o      (recovery_request_o),
        .bus_hold_o              (bus_hold_o),
        .resynch_pending_o       (resynch_pending_o),
        .unload_timeout_o        (unload_timeout_o),
        .mismatch_cnt_o          (mismatch_cnt_o),
        .state_o                 (state_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int model_cnt[N];
    int sat_max = (1 << CW) - 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*CW-1:0] model_vec();
        logic [N*CW-1:0] v;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(model_cnt[i]);
        return v;
    endfunction

    // One clock: the counter model follows the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (cnt_clear) model_cnt[i] = 0;
                else if (single_mismatch && error[i] && model_cnt[i] < sat_max) model_cnt[i]++;
            end
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int unload_cycles, resynch_pulses, full_setbacks, hold, pulses, d, r;
        rst_n = 1'b0;
        nmr_enable = 1; delay_resynch = 0; setback = 1; reload_setback = 1; rapid_recovery = 0;
        synch_req = 0; force_resynch = 0; cnt_clear = 0; single_mismatch = 0; failure = 0;
        error = '0; sp_zero = 1; will_be_zero = 0; fetch_en = 1; cores_synch = 0;
        recovery_finished = 0; bus_resp_ok = 0;
        for (int i = 0; i < N; i++) model_cnt[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", state_o, StRun);
        check("reset_cnt", mismatch_cnt_o, '0);
        check("reset_outs", {setback_o, sw_synch_req_o, sw_resynch_req_o, recovery_request_o,
                             bus_hold_o, resynch_pending_o, unload_timeout_o}, '0);
        check("reset_indep", grp_in_independent_o, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Delayed resynch: mismatch is buffered, released when delay drops.
        delay_resynch = 1; single_mismatch = 1; error = 5'b00001;
        tick();
        single_mismatch = 0; error = '0;
        check("dly_state", state_o, StRun);
        check("dly_pending", resynch_pending_o, 1'b1);
        check("dly_cnt0", mismatch_cnt_o[CW-1:0], 2'd1);
        check("dly_cnt", mismatch_cnt_o, model_vec());
        tick();
        check("dly_hold", state_o, StRun);
        delay_resynch = 0;
        tick();
        check("dly_unload", state_o, StUnload);
        check("dly_pending_clr", resynch_pending_o, 1'b0);

        // Watchdog: stack never drains, UNLOAD must end after UT cycles.
        unload_cycles = 0; resynch_pulses = 0; full_setbacks = 0;
        while (state_o == StUnload && unload_cycles < 40) begin
            if (sw_resynch_req_o) resynch_pulses++;
            if (setback_o == 5'b11111) full_setbacks++;
            unload_cycles++;
            tick();
        end
        check("wd_cycles", unload_cycles, UT);
        check("wd_resynch_pulses", resynch_pulses, 1);
        check("wd_setback_pulses", full_setbacks, 1);
        check("wd_flag", unload_timeout_o, 1'b1);
        check("wd_state", state_o, StReload);

        // RELOAD setback gating.
        sp_zero = 0; will_be_zero = 0; single_mismatch = 1; error = 5'b00010;
        #1 check("reload_setback", setback_o, 5'b11111);
        will_be_zero = 1;
        #1 check("reload_setback_wbz", setback_o, 5'b00000);
        single_mismatch = 0; error = '0; failure = 1; will_be_zero = 0;
        #1 check("reload_setback_fail", setback_o, 5'b11111);
        failure = 0;
        tick();
        check("reload_stay", state_o, StReload);
        sp_zero = 1;
        tick();
        check("reload_to_run", state_o, StRun);
        cnt_clear = 1;
        tick();
        cnt_clear = 0;
        check("clear_timeout", unload_timeout_o, 1'b0);
        check("clear_cnt", mismatch_cnt_o, model_vec());

        // Saturation on core 2, then clear beats a concurrent mismatch.
        delay_resynch = 1; single_mismatch = 1; error = 5'b00100;
        repeat (5) tick();
        check("sat_cnt2", mismatch_cnt_o[2*CW +: CW], 2'd3);
        check("sat_cnt", mismatch_cnt_o, model_vec());
        cnt_clear = 1;
        tick();
        cnt_clear = 0; single_mismatch = 0; error = '0;
        check("clr_vs_inc", mismatch_cnt_o, '0);
        check("sat_state", state_o, StRun);

        // fetch_en low wins over a trigger and drops the buffered request.
        fetch_en = 0; force_resynch = 1; delay_resynch = 0;
        tick();
        fetch_en = 1; force_resynch = 0;
        check("fetch_state", state_o, StRun);
        check("fetch_pending", resynch_pending_o, 1'b0);

        // Random mismatch/clear traffic against the counter model.
        delay_resynch = 1;
        for (int k = 0; k < 200; k++) begin
            single_mismatch = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, N));
            error = '0;
            if (r != 0) error[r-1] = 1'b1;
            cnt_clear = ($urandom_range(0, 15) == 0);
            tick();
            check("rand_cnt", mismatch_cnt_o, model_vec());
        end
        single_mismatch = 0; error = '0; cnt_clear = 0;
        check("rand_state", state_o, StRun);
        fetch_en = 0;
        tick();
        fetch_en = 1; delay_resynch = 0;
        check("rand_pending_clr", resynch_pending_o, 1'b0);

        // Leave redundancy with a delayed bus response.
        d = int'($urandom_range(2, 5));
        hold = 0;
        nmr_enable = 0;
        for (int c = 0; c <= d; c++) begin
            if (c == d) bus_resp_ok = 1;
            #1;
            if (bus_hold_o) hold++;
            if (c == d) check("leave_setback", setback_o, 5'b11110);
            tick();
        end
        bus_resp_ok = 0;
        check("leave_hold_cycles", hold, d + 1);
        check("leave_state", state_o, StIndep);
        check("leave_indep", grp_in_independent_o, 1'b1);
        check("leave_hold_off", bus_hold_o, 1'b0);

        // Re-enter: one synch pulse, RELOAD two cycles after cores_synch rises.
        nmr_enable = 1; synch_req = 1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (sw_synch_req_o) pulses++;
            tick();
        end
        check("synch_pulses", pulses, 1);
        check("synch_wait", state_o, StIndep);
        cores_synch = 1;
        tick();
        check("synch_reg_delay", state_o, StIndep);
        check("synch_setback", setback_o, 5'b11111);
        tick();
        check("synch_reload", state_o, StReload);
        cores_synch = 0; synch_req = 0;
        tick();
        check("synch_run", state_o, StRun);

        // Rapid recovery path.
        rapid_recovery = 1; force_resynch = 1;
        #1 check("rr_en", rapid_recovery_en_o, 1'b1);
        tick();
        force_resynch = 0;
        check("rr_state", state_o, StRapid);
        check("rr_request", recovery_request_o, 1'b1);
        d = int'($urandom_range(1, 3));
        for (int c = 0; c < d; c++) begin
            tick();
            check("rr_hold", state_o, StRapid);
        end
        recovery_finished = 1;
        tick();
        recovery_finished = 0;
        check("rr_done", state_o, StRun);
        check("rr_request_off", recovery_request_o, 1'b0);

        // Without rapid recovery the same trigger unloads.
        rapid_recovery = 0; sp_zero = 0; force_resynch = 1;
        tick();
        force_resynch = 0;
        check("norr_unload", state_o, StUnload);
        check("norr_setback", setback_o, 5'b11111);
        check("norr_resynch", sw_resynch_req_o, 1'b1);
        tick();
        check("norr_reload", state_o, StReload);
        sp_zero = 1;
        tick();
        check("norr_run", state_o, StRun);

        // Asynchronous reset in the middle of an unload.
        single_mismatch = 1; error = 5'b00001;
        tick();
        single_mismatch = 0; error = '0;
        check("mid_unload", state_o, StUnload);
        check("mid_cnt", mismatch_cnt_o, model_vec());
        #2 rst_n = 1'b0;
        for (int i = 0; i < N; i++) model_cnt[i] = 0;
        #1;
        check("mid_reset_state", state_o, StRun);
        check("mid_reset_cnt", mismatch_cnt_o, model_vec());
        check("mid_reset_resynch", sw_resynch_req_o, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_reset_state", state_o, StRun);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hmr_nmr_ctrl.md
# hmr_nmr_ctrl

Parametrised N-modular-redundancy control unit for one HMR core group. It generalises the TMR lockstep controller to `NumCores` replicas. It adds three things the TMR controller lacks: buffering of resynchronisation requests while `delay_resynch_i` is set, per-core saturating mismatch counters, and an unload watchdog. It sits between the HMR configuration registers and the group's voter, software-recovery and rapid-recovery logic.

## Interface
- `NumCores`, 3: replicas in the group; odd, ≥3
- `CntWidth`, 8: width of each per-core mismatch counter
- `UnloadTimeout`, 0: maximum cycles in UNLOAD; 0 disables the watchdog
- `NMRFixed`, 0: group is permanently redundant
- `DefaultInNMR`, `NMRFixed`: reset state is RUN rather than INDEP
- `RapidRecovery`, 0: rapid-recovery hardware is present
- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous, active-low reset
- `nmr_enable_i`, `delay_resynch_i`, `setback_i`, `reload_setback_i`, `rapid_recovery_i`, `synch_req_i` in 1 each: configuration levels
- `force_resynch_i` in 1: single-cycle resynchronisation request pulse
- `cnt_clear_i` in 1: clears all counters and `unload_timeout_o`
- `single_mismatch_i` in 1: one replica disagrees with the vote
- `error_i` in NumCores: one-hot or zero; identifies the faulty replica
- `failure_i` in 1: no majority
- `sp_store_is_zero_i`, `sp_store_will_be_zero_i` in 1 each: software-recovery stack status
- `fetch_en_i`, `cores_synch_i`, `recovery_finished_i`, `bus_resp_ok_i` in 1 each
- `setback_o` out NumCores: per-core reset pulse
- `sw_synch_req_o`, `sw_resynch_req_o` out 1 each: one-cycle pulses
- `grp_in_independent_o`, `rapid_recovery_en_o`, `recovery_request_o`, `bus_hold_o` out 1 each
- `resynch_pending_o` out 1: a resynchronisation is buffered
- `unload_timeout_o` out 1: sticky watchdog flag
- `mismatch_cnt_o` out NumCores×CntWidth: per-core saturating counters
- `state_o` out 3: current FSM state

## Operation
- States: INDEP, RUN, UNLOAD, RELOAD, RAPID.
- Internal rapid-recovery enable `rr` = `rapid_recovery_i & RapidRecovery`; `rapid_recovery_en_o` = `rr`.
- RUN, on a trigger (`force_resynch_i`, or `single_mismatch_i`, or `pending_q`):
  - if `rr`: go to RAPID.
  - else if `delay_resynch_i` = 0: go to UNLOAD.
  - else: set `pending_q`.
- `pending_q` clears on the cycle RUN exits to RAPID or UNLOAD.
- `single_mismatch_i` in any state increments `mismatch_cnt[i]` for each set `error_i[i]`. Counters saturate at all-ones. `cnt_clear_i` wins over a same-cycle increment.
- UNLOAD:
  - internal resynch request is high.
  - when `sp_store_is_zero_i` = 0: go to RELOAD; pulse `setback_o` = all ones if `setback_i`.
  - watchdog: if `UnloadTimeout` ≠ 0 and the cycle counter reaches `UnloadTimeout`: set `unload_timeout_o`, go to RELOAD, pulse `setback_o` = all ones regardless of `setback_i`.
- RELOAD:
  - when `sp_store_is_zero_i`: go to RUN.
  - else, if (`single_mismatch_i` | `failure_i`) & `setback_i` & `reload_setback_i` & !`sp_store_will_be_zero_i`: pulse `setback_o` = all ones.
- RAPID: `recovery_request_o` = 1; on `recovery_finished_i` go to RUN.
- Mode switching, skipped entirely when `NMRFixed`. Later items override earlier ones.
  1. INDEP with `nmr_enable_i`: internal synch request = `synch_req_i`. When `cores_synch_q`: go to RAPID if `rr`, else go to RELOAD and pulse all-ones `setback_o` if `setback_i`.
  2. RUN with `nmr_enable_i` = 0: `bus_hold_o` = 1. On `bus_resp_ok_i`: go to INDEP; `setback_o` = all ones except bit 0 if `setback_i`.
  3. `fetch_en_i` = 0: next state = RUN if `nmr_enable_i`, else INDEP. Synch request is suppressed and `pending_q` is cleared.
- `grp_in_independent_o` = (state == INDEP).

## Timing
- Reset values:
  - state = RUN if `DefaultInNMR`, else INDEP.
  - counters, `pending_q`, watchdog and sent-flags = 0.
  - `cores_synch_q` = 0.
  - all pulse outputs = 0.
- Request outputs are rising-edge detectors on registered flags: `sw_*_req_o` = req & ~req_sent_q. Result: one pulse per entry into UNLOAD, or per rising edge of the synch request.
- `cores_synch_i` is registered; the INDEP→RELOAD transition happens 2 cycles after `cores_synch_i` rises.
- `setback_o`, `bus_hold_o` and `recovery_request_o` are combinational from the state and inputs in the same cycle.
- The watchdog counter resets on UNLOAD entry. It counts each cycle spent in UNLOAD and is CntWidth-independent: its width is `$clog2(UnloadTimeout+1)`.
- Simultaneous trigger and `fetch_en_i` = 0: the `fetch_en_i` rule wins.
- Reset asserted mid-recovery returns to the reset state immediately. The counters are lost.

## Structure
- `hmr_pkg` holds the `nmr_mode_e` enum (3-bit) and a `state_o` encoding shared with the TMR and DMR controllers.
- One sub-module, `hmr_sat_counter`, instantiated `NumCores` times. Parameters: width; enable, clear, count.
- No register file inside this block.

## Test plan
- Watchdog: `UnloadTimeout`=16, `sp_store_is_zero_i` held 1 in UNLOAD → `unload_timeout_o` rises after 16 cycles; state RELOAD; `setback_o`=all ones for 1 cycle.
- Delayed resynch: `delay_resynch_i`=1, mismatch with `error_i`=001 → state stays RUN, `resynch_pending_o`=1, `cnt[0]`=1. Drop `delay_resynch_i` → UNLOAD next cycle and a single `sw_resynch_req_o` pulse.
- Counter saturation: `CntWidth`=2, 5 mismatches on core 2 → `cnt[2]`=3. `cnt_clear_i` concurrent with a mismatch → 0.
- NumCores=5 leave redundancy: `nmr_enable_i`=0 in RUN, `bus_resp_ok_i` delayed 3 cycles → `bus_hold_o` high 4 cycles; then `setback_o`=11110; state INDEP.
- Re-enter: INDEP, `nmr_enable_i`=1, `synch_req_i`=1 → one `sw_synch_req_o` pulse. `cores_synch_i` rises → RELOAD 2 cycles later. `sp_store_is_zero_i` → RUN.
- Rapid recovery: `RapidRecovery`=1, `rapid_recovery_i`=1, `force_resynch_i` → RAPID with `recovery_request_o`=1. `recovery_finished_i` → RUN. `RapidRecovery`=0 → UNLOAD instead.
